// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - enable-gated up-counter with a registered Gray-coded output
module gray_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;

  assign bin_next  = bin + {{(WIDTH-1){1'b0}}, 1'b1};
  // Gray value comes from the incremented count so out updates on the same edge as bin.
  assign gray_next = bin_next ^ (bin_next >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      bin <= '0;
      out <= '0;
    end else if (enable) begin
      bin <= bin_next;
      out <= gray_next;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - directed and random-enable self-checking bench for gray_counter
module tb_gray_counter;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] out;

  int checks;
  int errors;

  gray_counter #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic e);
    reset  = r;
    enable = e;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [7:0] seq_exp [8] = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h0C};

  initial begin
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] refbin;
    logic             e;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    enable = 1'b1;

    // reset overrides enable
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1);
      check("reset", out, 8'h00);
    end

    // first eight Gray codes, one bit per step
    prev = out;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1);
      check("seq", out, seq_exp[i]);
      check("seq_ham", $countones(prev ^ out), 1);
      prev = out;
    end

    // hold and resume
    step(1'b1, 1'b0);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1);
    check("count25", out, 8'h15);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      check("hold", out, 8'h15);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    check("resume", out, 8'h32);

    // reset priority mid-count
    step(1'b1, 1'b0);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1);
    check("pre_rst", out, 8'h15);
    step(1'b1, 1'b1);
    check("mid_rst", out, 8'h00);
    step(1'b0, 1'b1);
    check("post_rst", out, 8'h01);

    // wrap-around
    step(1'b1, 1'b0);
    for (int i = 0; i < 255; i++) step(1'b0, 1'b1);
    check("wrap255", out, 8'h80);
    step(1'b0, 1'b1);
    check("wrap256", out, 8'h00);
    step(1'b0, 1'b1);
    check("wrap257", out, 8'h01);

    // random enable against a binary reference
    step(1'b1, 1'b0);
    refbin = '0;
    for (int i = 0; i < 1024; i++) begin
      e    = 1'($urandom_range(0, 1));
      prev = out;
      step(1'b0, e);
      if (e) refbin = refbin + 8'd1;
      check("rand_ham", $countones(prev ^ out), e ? 1 : 0);
      check("rand_bin", gray2bin(out), refbin);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
